// File: rtl/rock_search_ctrl_if.sv
// Control/status bundle between a rocking-search controller and its host:
// enable/feedback/rescan requests in, amplitude/frequency set-points and status out.
interface rock_search_ctrl_if #(
  parameter int AW = 3,
  parameter int FW = 3
);
  logic          enable;
  logic          stress_dec;
  logic          rescan;
  logic [AW-1:0] amp;
  logic [FW-1:0] freq;
  logic          busy;
  logic          locked;
  logic          err;

  modport master (
    output enable, stress_dec, rescan,
    input  amp, freq, busy, locked, err
  );

  modport slave (
    input  enable, stress_dec, rescan,
    output amp, freq, busy, locked, err
  );
endinterface

// File: rtl/rock_search_ctrl.sv
// Coordinate-search rocker controller: steps amplitude or frequency one unit at a time,
// waits a settle window, then keeps or reverts the step based on a stress-decreased bit.
module rock_search_ctrl #(
  parameter int AW            = 3,
  parameter int FW            = 3,
  parameter int A_INIT        = 0,
  parameter int F_INIT        = 4,
  parameter int SETTLE_CYCLES = 50000000,
  parameter int MAX_TRIALS    = 64
) (
  input logic               clk,
  input logic               reset,
  rock_search_ctrl_if.slave bus
);

  localparam int TW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int NW = $clog2(MAX_TRIALS + 1);
  localparam int SW = (AW > FW) ? AW : FW;

  localparam logic [TW-1:0] TIMER_LOAD  = TW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0] TRIAL_LIMIT = NW'(MAX_TRIALS);
  localparam logic [AW-1:0] AMP_INIT    = AW'(A_INIT);
  localparam logic [FW-1:0] FREQ_INIT   = FW'(F_INIT);
  localparam logic [AW-1:0] AMP_MAX     = '1;
  localparam logic [FW-1:0] FREQ_MAX    = '1;
  localparam logic [2:0]    MISS_LOCK   = 3'd4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STEP   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic [2:0]    state, state_n;
  logic [AW-1:0] amp, amp_n;
  logic [FW-1:0] freq, freq_n;
  logic [1:0]    combo, combo_n;
  logic [2:0]    miss, miss_n;
  logic [NW-1:0] trials, trials_n;
  logic [TW-1:0] timer, timer_n;
  logic [SW-1:0] saved, saved_n;

  logic          on_amp;
  logic          step_up;
  logic          saturated;
  logic [2:0]    miss_inc;
  logic [AW-1:0] amp_stepped;
  logic [FW-1:0] freq_stepped;

  // Combo index bit 0 selects the axis, bit 1 selects the direction.
  assign on_amp       = ~combo[0];
  assign step_up      = ~combo[1];
  assign miss_inc     = miss + 3'd1;
  assign amp_stepped  = step_up ? amp + AW'(1) : amp - AW'(1);
  assign freq_stepped = step_up ? freq + FW'(1) : freq - FW'(1);

  always_comb begin
    saturated = 1'b0;
    case ({on_amp, step_up})
      2'b11:   saturated = (amp == AMP_MAX);
      2'b10:   saturated = (amp == '0);
      2'b01:   saturated = (freq == FREQ_MAX);
      default: saturated = (freq == '0);
    endcase
  end

  always_comb begin
    state_n  = state;
    amp_n    = amp;
    freq_n   = freq;
    combo_n  = combo;
    miss_n   = miss;
    trials_n = trials;
    timer_n  = timer;
    saved_n  = saved;

    if (!bus.enable) begin
      state_n  = S_IDLE;
      amp_n    = AMP_INIT;
      freq_n   = FREQ_INIT;
      combo_n  = '0;
      miss_n   = '0;
      trials_n = '0;
      timer_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n  = S_STEP;
          combo_n  = '0;
          miss_n   = '0;
          trials_n = '0;
        end

        S_STEP: begin
          if (trials == TRIAL_LIMIT) begin
            state_n = S_FAULT;
          end else if (saturated) begin
            // A blocked direction counts as a miss without spending a trial.
            miss_n  = miss_inc;
            combo_n = combo + 2'd1;
            if (miss_inc == MISS_LOCK)
              state_n = S_LOCKED;
          end else begin
            if (on_amp) begin
              saved_n = SW'(amp);
              amp_n   = amp_stepped;
            end else begin
              saved_n = SW'(freq);
              freq_n  = freq_stepped;
            end
            trials_n = trials + NW'(1);
            timer_n  = TIMER_LOAD;
            state_n  = S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (timer == '0)
            state_n = S_DECIDE;
          else
            timer_n = timer - TW'(1);
        end

        S_DECIDE: begin
          state_n = S_STEP;
          if (bus.stress_dec) begin
            miss_n = '0;
          end else begin
            if (on_amp)
              amp_n = saved[AW-1:0];
            else
              freq_n = saved[FW-1:0];
            miss_n  = miss_inc;
            combo_n = combo + 2'd1;
            if (miss_inc == MISS_LOCK)
              state_n = S_LOCKED;
          end
        end

        S_LOCKED: begin
          if (bus.rescan) begin
            state_n  = S_STEP;
            combo_n  = '0;
            miss_n   = '0;
            trials_n = '0;
          end
        end

        S_FAULT: state_n = S_FAULT;

        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      amp    <= AMP_INIT;
      freq   <= FREQ_INIT;
      combo  <= '0;
      miss   <= '0;
      trials <= '0;
      timer  <= '0;
      saved  <= '0;
    end else begin
      state  <= state_n;
      amp    <= amp_n;
      freq   <= freq_n;
      combo  <= combo_n;
      miss   <= miss_n;
      trials <= trials_n;
      timer  <= timer_n;
      saved  <= saved_n;
    end
  end

  assign bus.amp    = amp;
  assign bus.freq   = freq;
  assign bus.busy   = (state == S_STEP) || (state == S_SETTLE) || (state == S_DECIDE);
  assign bus.locked = (state == S_LOCKED);
  assign bus.err    = (state == S_FAULT);

endmodule
